// File: rtl/gray_pkg.sv
// Shared types and constants for the Gray-code conversion arbiter.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
package gray_pkg;

  localparam int GRAY_W = 4;
  localparam int N_REQ  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RESP = 2'd2
  } state_t;

  // MSB passes straight through; each lower bit folds in the running
  // parity of everything above it.
  function automatic logic [GRAY_W-1:0] gray_to_bin(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] b;
    b = '0;
    b[GRAY_W-1] = g[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational 4-bit Gray-to-binary converter.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows input.
// Ports: gray - Gray-coded input; bin - binary equivalent.
module gray2bin
  import gray_pkg::*;
(
  input  logic [GRAY_W-1:0] gray,
  output logic [GRAY_W-1:0] bin
);

  always_comb begin
    bin = gray_to_bin(gray);
  end

endmodule

// File: rtl/gray_conv_arb.sv
// Two-requester arbiter sharing one Gray-to-binary converter.
// Latency: accept in cycle T -> rsp_valid in cycle T+2; next accept no earlier than T+3.
// Backpressure: holds the result in RESP while rsp_ready is low; req_ready stays 0 meanwhile.
// Ports: clk/rst (sync, active-high); req_valid/req_gray0/req_gray1 in, req_ready one-hot grant out;
//        rsp_valid/rsp_id/rsp_bin out with rsp_ready in; busy high whenever not IDLE.
module gray_conv_arb
  import gray_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req_valid,
  input  logic [GRAY_W-1:0] req_gray0,
  input  logic [GRAY_W-1:0] req_gray1,
  output logic [N_REQ-1:0]  req_ready,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [GRAY_W-1:0] rsp_bin,
  input  logic              rsp_ready,
  output logic              busy
);

  state_t            state;
  logic              last_grant;  // index of the requester granted most recently
  logic              winner;
  logic              accept;
  logic [GRAY_W-1:0] gray_sel;
  logic [GRAY_W-1:0] gray_q;
  logic [GRAY_W-1:0] bin_conv;
  logic [GRAY_W-1:0] bin_q;
  logic              id_q;

  // Tie-break: round-robin favours the requester not granted last,
  // fixed priority always favours requester 0.
  always_comb begin
    winner = 1'b0;
    case (req_valid)
      2'b10:   winner = 1'b1;
      2'b11:   winner = (RR_EN != 0) ? ~last_grant : 1'b0;
      default: winner = 1'b0;
    endcase
  end

  // Grant is only offered from IDLE, and never while reset is applied.
  always_comb begin
    req_ready = '0;
    if (!rst && (state == IDLE) && (req_valid != '0)) begin
      req_ready[winner] = 1'b1;
    end
  end

  assign accept   = |(req_valid & req_ready);
  assign gray_sel = winner ? req_gray1 : req_gray0;

  gray2bin u_gray2bin (
    .gray (gray_q),
    .bin  (bin_conv)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;  // "last was 1" makes requester 0 win the first tie
      gray_q     <= '0;
      id_q       <= 1'b0;
      bin_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            gray_q     <= gray_sel;
            id_q       <= winner;
            last_grant <= winner;
            state      <= CONV;
          end
        end
        CONV: begin
          bin_q <= bin_conv;
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_id    = id_q;
  assign rsp_bin   = bin_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_gray_conv_arb.sv
// Self-checking bench for gray_conv_arb: directed scenarios plus random traffic
// against a transaction-level reference model.
// Two instances: round-robin (main) and fixed-priority.
module tb_gray_conv_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [3:0] req_gray0, req_gray1;
  logic [1:0] req_ready;
  logic       rsp_valid, rsp_id, rsp_ready, busy;
  logic [3:0] rsp_bin;

  logic [1:0] fp_req_valid;
  logic [3:0] fp_req_gray0, fp_req_gray1;
  logic [1:0] fp_req_ready;
  logic       fp_rsp_valid, fp_rsp_id, fp_rsp_ready, fp_busy;
  logic [3:0] fp_rsp_bin;

  always #5 clk = ~clk;

  gray_conv_arb #(.RR_EN(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_gray0(req_gray0),
    .req_gray1(req_gray1), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_bin(rsp_bin), .rsp_ready(rsp_ready), .busy(busy)
  );

  gray_conv_arb #(.RR_EN(0)) dut_fp (
    .clk(clk), .rst(rst), .req_valid(fp_req_valid), .req_gray0(fp_req_gray0),
    .req_gray1(fp_req_gray1), .req_ready(fp_req_ready), .rsp_valid(fp_rsp_valid),
    .rsp_id(fp_rsp_id), .rsp_bin(fp_rsp_bin), .rsp_ready(fp_rsp_ready), .busy(fp_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Binary value of a Gray code: XOR of the code with all its right shifts.
  function automatic logic [3:0] ref_bin(input logic [3:0] g);
    return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
  endfunction

  // Reference model (transaction level).
  int         cyc = 0;
  bit         m_inflight = 0;
  bit         m_pref = 0;       // requester that wins a tie
  bit         m_id;
  logic [3:0] m_bin;
  int         m_due;            // cycle in which the response must appear
  bit         log_id[$];
  logic [3:0] log_bin[$];

  // Snapshot of DUT outputs taken at the last negedge.
  logic [1:0] obs_ready;
  logic       obs_valid, obs_id, obs_busy;
  logic [3:0] obs_bin;

  // One clock cycle: inputs are already applied; check at negedge, then
  // advance to just after the next rising edge.
  task automatic step();
    bit         w;
    logic [1:0] exp_rdy;
    bit         ev;
    @(negedge clk);
    obs_ready = req_ready; obs_valid = rsp_valid; obs_id = rsp_id;
    obs_bin   = rsp_bin;   obs_busy  = busy;
    if (rst) begin
      check_eq("ready_in_reset", req_ready, 0);
      m_inflight = 0;
      m_pref     = 0;
    end else if (!m_inflight) begin
      if (req_valid == 2'b11) w = m_pref;
      else                    w = req_valid[1] && !req_valid[0];
      exp_rdy = (req_valid != 0) ? (2'b01 << w) : 2'b00;
      check_eq("idle_ready", req_ready, exp_rdy);
      check_eq("idle_busy", busy, 0);
      check_eq("idle_rsp_valid", rsp_valid, 0);
      if (req_valid != 0) begin
        m_inflight = 1;
        m_id       = w;
        m_bin      = ref_bin(w ? req_gray1 : req_gray0);
        m_due      = cyc + 2;
        m_pref     = !w;
      end
    end else begin
      ev = (cyc >= m_due);
      check_eq("busy_ready", req_ready, 0);
      check_eq("busy_flag", busy, 1);
      check_eq("rsp_valid", rsp_valid, ev);
      if (ev) begin
        check_eq("rsp_id", rsp_id, m_id);
        check_eq("rsp_bin", rsp_bin, m_bin);
        if (rsp_ready) begin
          m_inflight = 0;
          log_id.push_back(rsp_id);
          log_bin.push_back(rsp_bin);
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; req_valid = 0; rsp_ready = 1;
    step();
    rst = 0;
    step();
    check_eq("rst_ready", obs_ready, 0);
    check_eq("rst_valid", obs_valid, 0);
    check_eq("rst_id", obs_id, 0);
    check_eq("rst_bin", obs_bin, 0);
    check_eq("rst_busy", obs_busy, 0);
    log_id.delete();
    log_bin.delete();
  endtask

  initial begin
    int fp_resp;
    rst = 1; req_valid = 0; req_gray0 = 0; req_gray1 = 0; rsp_ready = 1;
    fp_req_valid = 0; fp_req_gray0 = 0; fp_req_gray1 = 0; fp_rsp_ready = 1;
    @(posedge clk);
    #1;
    do_reset();

    // Single request with fixed two-cycle latency.
    req_valid = 2'b01; req_gray0 = 4'b0110;
    step();
    req_valid = 0; req_gray0 = 4'b1111;  // later changes must not leak in
    step();
    step();
    check_eq("single_valid", obs_valid, 1);
    check_eq("single_id", obs_id, 0);
    check_eq("single_bin", obs_bin, 4'b0100);

    // Simultaneous requests, round-robin.
    do_reset();
    req_valid = 2'b11; req_gray0 = 4'b0001; req_gray1 = 4'b0011;
    for (int i = 0; i < 10; i++) step();
    req_valid = 0;
    check_eq("rr_count", log_id.size(), 3);
    if (log_id.size() >= 3) begin
      check_eq("rr_first_id", log_id[0], 0);
      check_eq("rr_first_bin", log_bin[0], 4'b0001);
      check_eq("rr_second_id", log_id[1], 1);
      check_eq("rr_second_bin", log_bin[1], 4'b0010);
      check_eq("rr_third_id", log_id[2], 0);
    end

    // Backpressure.
    do_reset();
    req_valid = 2'b10; req_gray1 = 4'b1000; rsp_ready = 0;
    step();
    req_valid = 2'b11; req_gray0 = 4'b0101; req_gray1 = 4'b0011;
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("bp_valid", obs_valid, 1);
      check_eq("bp_bin", obs_bin, 4'b1111);
      check_eq("bp_ready", obs_ready, 0);
    end
    req_valid = 0; rsp_ready = 1;
    step();
    check_eq("bp_release_id", obs_id, 1);

    // Reset while converting.
    do_reset();
    req_valid = 2'b01; req_gray0 = 4'b1010;
    step();
    req_valid = 0; rst = 1;
    step();
    rst = 0;
    step();
    check_eq("midrst_ready", obs_ready, 0);
    check_eq("midrst_valid", obs_valid, 0);
    check_eq("midrst_id", obs_id, 0);
    check_eq("midrst_bin", obs_bin, 0);
    check_eq("midrst_busy", obs_busy, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("midrst_no_rsp", obs_valid, 0);
    end

    // Every code through each requester.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 16; c++) begin
        req_valid = 2'b01 << r;
        req_gray0 = 4'(c); req_gray1 = 4'(c);
        step();
        req_valid = 0; req_gray0 = 4'(~c); req_gray1 = 4'(~c);
        step();
        step();
        check_eq("exh_id", obs_id, r);
        check_eq("exh_bin", obs_bin, ref_bin(4'(c)));
      end
    end

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      req_valid = 2'($urandom_range(0, 3));
      req_gray0 = 4'($urandom);
      req_gray1 = 4'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
      rst       = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 0; req_valid = 0; rsp_ready = 1;
    step();

    // Fixed priority on the second instance.
    fp_req_valid = 2'b11; fp_req_gray0 = 4'b0101; fp_req_gray1 = 4'b1001;
    fp_resp = 0;
    for (int i = 0; i < 40 && fp_resp < 3; i++) begin
      @(negedge clk);
      if (fp_rsp_valid) begin
        check_eq("fp_id", fp_rsp_id, 0);
        check_eq("fp_bin", fp_rsp_bin, ref_bin(4'b0101));
        fp_resp++;
      end
      @(posedge clk);
      #1;
    end
    check_eq("fp_resp_count", fp_resp, 3);
    fp_req_valid = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
